decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode (ID) stage of the 5-stage MIPS pipeline; the consumer end of the IF/ID interface driven by the fetch stage.
- Takes instrD, pcD and pcplus4D. Decodes control, reads the 32x32 register file and sign-extends the immediate.
- Registers the results into the ID/EX pipeline register.
- Accepts the writeback port from WB. Squashes wrong-path instructions when Execute reports a taken branch.

Parameters:
- NREG, 32, number of architectural registers (index width 5).
- RESET_PC, 32'h00000000, value loaded into pcE/pcplus4E on reset and on bubbles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instrD  in  32  instruction from IF/ID
- pcD  in  32  PC of instrD
- pcplus4D  in  32  PC+4 of instrD
- isbranchtakenE  in  1  branch resolved taken in EX this cycle
- regwriteW  in  1  writeback enable
- rdW  in  5  writeback destination
- resultW  in  32  writeback data
- regwriteE, memwriteE, memtoregE, alusrcE, regdstE, branchE  out  1 each  registered control
- alucontrolE  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- rd1E, rd2E  out  32  register read data
- immE  out  32  sign-extended instr[15:0]
- rsE, rtE, rdE  out  5  register fields
- pcE, pcplus4E  out  32  passed through
- illegalE  out  1  unsupported opcode/funct seen in D

Behaviour:
- Reset is synchronous, active-high; all logic uses the single clock clk.
- Reset:
  - All ID/EX outputs are 0, except pcE = pcplus4E = RESET_PC.
  - squash_pending = 0.
  - Register file is cleared to 0.
- Latency: one cycle, D inputs to E outputs.
- Decode table (opcode, funct):
  - R-type 000000: regwrite=1, regdst=1. Funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is illegal.
  - lw 100011: regwrite, alusrc, memtoreg, add.
  - sw 101011: memwrite, alusrc, add.
  - beq 000100: branch, sub.
  - addi 001000: regwrite, alusrc, add.
  - Any other opcode is illegal.
- An illegal instruction enters ID/EX with all control bits 0 and illegalE=1.
- All-zero instruction (the fetch reset value) is R-type funct 000000 and so illegal. It is therefore forced to a plain bubble instead: no flag, all control 0.
- Register file:
  - $0 reads 0 always; writes to $0 are ignored.
  - Write occurs on posedge when regwriteW=1.
  - Reads are combinational on instrD[25:21] and [20:16].
- Squash:
  - The fetch stage does not flush IF/ID, so a taken branch leaves two wrong-path instructions: the one in D now and the one arriving next cycle.
  - When isbranchtakenE=1: ID/EX loads a bubble this edge and squash_pending is set to 1.
  - When squash_pending=1: ID/EX loads a bubble and squash_pending clears.
  - If isbranchtakenE=1 while squash_pending=1: bubble, and squash_pending stays 1.
  - A bubble means all control bits 0, illegalE=0, data fields 0 and pc fields RESET_PC.
  - Writeback is never blocked by a squash.
- Reset mid-squash: rst has priority and clears squash_pending.

Optional Feature:
- Macro: DECODE_REGFILE_BYPASS_EN.
- Defined: when regwriteW=1, rdW!=0 and rdW equals rs (or rt), the corresponding read returns resultW in the same cycle (write-through).
- Undefined: the read returns the pre-write stored value. WB-to-ID hazards must then be covered by an extra stall or NOP.

Decomposition:
- Shared package decode_pkg holds:
  - opcode and funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, FN_ADD ...).
  - ALU control encodings (ALU_ADD=3'b010 etc.).
  - A bundled ID/EX control struct typedef.
- One sub-module, reg_file: 32x32, two read ports, one write port, with the bypass option inside it.

Test Plan:
- Reset then addi $1,$0,5 (32'h20010005) -> next cycle: regwriteE=1, alusrcE=1, alucontrolE=010, immE=5, rtE=1, rd1E=0.
- Write path: regwriteW=1, rdW=3, resultW=32'hDEADBEEF; then add $4,$3,$0 -> rd1E=DEADBEEF, regdstE=1, rdE=4. Writing rdW=0 with 1234 -> $0 still reads 0.
- Same-cycle hazard: rdW=5, resultW=77 while instrD reads $5:
  - bypass defined -> rd1E=77.
  - bypass undefined -> old value (0 after reset).
- Branch squash: isbranchtakenE pulsed 1 cycle with valid lw, then sw in D -> both leave as bubbles (memtoregE=0, memwriteE=0). The third instruction decodes normally.
- Back-to-back taken branches on consecutive cycles -> three consecutive bubbles, then normal decode.
- Illegal: instr 32'hFC000000 -> illegalE=1 and all control 0. Instr 32'h00000000 -> bubble, illegalE=0. beq (32'h10220003) -> branchE=1, alucontrolE=110, immE=3.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: MIPS opcode/funct and ALU encodings, ID/EX control bundle, instruction decoder
package decode_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctrl_t;
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.regdst = 1'b1;
        case (instr[5:0])
          FN_ADD: c.alucontrol = ALU_ADD;
          FN_SUB: c.alucontrol = ALU_SUB;
          FN_AND: c.alucontrol = ALU_AND;
          FN_OR:  c.alucontrol = ALU_OR;
          FN_SLT: c.alucontrol = ALU_SLT;
          default: begin
            c = '0;
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.memtoreg = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrc = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      default: c.illegal = 1'b1;
    endcase
    // the fetch reset value would otherwise flag as illegal; treat it as a bubble
    if (instr == '0) c = '0;
    return c;
  endfunction
endpackage

// File: rtl/decode_stage_reg_file.sv
// decode_stage_reg_file: NREGx32 regfile, 2 comb reads (ra1/ra2->rd1/rd2), 1 write (we/wa/wd), $0 hardwired; DECODE_REGFILE_BYPASS_EN adds write-through
module decode_stage_reg_file #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [NREG];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end
`ifdef DECODE_REGFILE_BYPASS_EN
  always_comb begin
    rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs[ra1];
    rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs[ra2];
  end
`else
  always_comb begin
    rd1 = ra1 == '0 ? '0 : regs[ra1];
    rd2 = ra2 == '0 ? '0 : regs[ra2];
  end
`endif
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage; IF/ID in (instrD/pcD/pcplus4D), WB port in, isbranchtakenE squash in, registered ID/EX out; DECODE_REGFILE_BYPASS_EN enables regfile write-through
module decode_stage
  import decode_pkg::*;
#(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrD,
  input  logic [31:0] pcD,
  input  logic [31:0] pcplus4D,
  input  logic        isbranchtakenE,
  input  logic        regwriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  output logic        regwriteE,
  output logic        memwriteE,
  output logic        memtoregE,
  output logic        alusrcE,
  output logic        regdstE,
  output logic        branchE,
  output logic [2:0]  alucontrolE,
  output logic [31:0] rd1E,
  output logic [31:0] rd2E,
  output logic [31:0] immE,
  output logic [4:0]  rsE,
  output logic [4:0]  rtE,
  output logic [4:0]  rdE,
  output logic [31:0] pcE,
  output logic [31:0] pcplus4E,
  output logic        illegalE
);
  ctrl_t       ctrl_d, ctrl_e;
  logic [31:0] rd1_d, rd2_d;
  logic        squash_pending;
  logic        bubble;
  decode_stage_reg_file #(.NREG(NREG)) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(instrD[25:21]),
    .ra2(instrD[20:16]),
    .rd1(rd1_d),
    .rd2(rd2_d),
    .we(regwriteW),
    .wa(rdW),
    .wd(resultW)
  );
  always_comb begin
    ctrl_d = decode(instrD);
    bubble = isbranchtakenE | squash_pending;
  end
  // a taken branch leaves two wrong-path instructions in IF/ID; squash this one and the next
  always_ff @(posedge clk) begin
    squash_pending <= !rst && isbranchtakenE;
    if (rst || bubble) begin
      ctrl_e   <= '0;
      rd1E     <= '0;
      rd2E     <= '0;
      immE     <= '0;
      rsE      <= '0;
      rtE      <= '0;
      rdE      <= '0;
      pcE      <= RESET_PC;
      pcplus4E <= RESET_PC;
    end else begin
      ctrl_e   <= ctrl_d;
      rd1E     <= rd1_d;
      rd2E     <= rd2_d;
      immE     <= {{16{instrD[15]}}, instrD[15:0]};
      rsE      <= instrD[25:21];
      rtE      <= instrD[20:16];
      rdE      <= instrD[15:11];
      pcE      <= pcD;
      pcplus4E <= pcplus4D;
    end
  end
  always_comb begin
    regwriteE   = ctrl_e.regwrite;
    memwriteE   = ctrl_e.memwrite;
    memtoregE   = ctrl_e.memtoreg;
    alusrcE     = ctrl_e.alusrc;
    regdstE     = ctrl_e.regdst;
    branchE     = ctrl_e.branch;
    alucontrolE = ctrl_e.alucontrol;
    illegalE    = ctrl_e.illegal;
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD, pcD, pcplus4D, resultW;
  logic        isbranchtakenE, regwriteW;
  logic [4:0]  rdW;
  logic        regwriteE, memwriteE, memtoregE, alusrcE, regdstE, branchE, illegalE;
  logic [2:0]  alucontrolE;
  logic [31:0] rd1E, rd2E, immE, pcE, pcplus4E;
  logic [4:0]  rsE, rtE, rdE;
  int          passed = 0;
  int          total = 0;
  decode_stage dut (
    .clk(clk), .rst(rst), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
    .isbranchtakenE(isbranchtakenE), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW),
    .regwriteE(regwriteE), .memwriteE(memwriteE), .memtoregE(memtoregE), .alusrcE(alusrcE),
    .regdstE(regdstE), .branchE(branchE), .alucontrolE(alucontrolE), .rd1E(rd1E), .rd2E(rd2E),
    .immE(immE), .rsE(rsE), .rtE(rtE), .rdE(rdE), .pcE(pcE), .pcplus4E(pcplus4E), .illegalE(illegalE)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] haz_exp;
    rst = 1'b1;
    instrD = 32'h20010005;
    pcD = 32'h100;
    pcplus4D = 32'h104;
    isbranchtakenE = 1'b0;
    regwriteW = 1'b0;
    rdW = '0;
    resultW = '0;
    tick();
    tick();
    check("rst_regwrite", regwriteE, 0);
    check("rst_alusrc", alusrcE, 0);
    check("rst_imm", immE, 0);
    check("rst_rt", rtE, 0);
    check("rst_pc", pcE, 32'h0);
    check("rst_pc4", pcplus4E, 32'h0);
    check("rst_illegal", illegalE, 0);
    rst = 1'b0;
    tick();
    check("addi_regwrite", regwriteE, 1);
    check("addi_alusrc", alusrcE, 1);
    check("addi_aluctl", alucontrolE, 3'b010);
    check("addi_imm", immE, 5);
    check("addi_rt", rtE, 1);
    check("addi_rd1", rd1E, 0);
    check("addi_regdst", regdstE, 0);
    check("addi_pc", pcE, 32'h100);
    check("addi_pc4", pcplus4E, 32'h104);
    regwriteW = 1'b1; rdW = 5'd3; resultW = 32'hDEADBEEF; instrD = 32'h0;
    tick();
    check("zero_bubble_illegal", illegalE, 0);
    check("zero_bubble_regwrite", regwriteE, 0);
    regwriteW = 1'b0; instrD = 32'h00602020;
    tick();
    check("add_rd1", rd1E, 32'hDEADBEEF);
    check("add_regdst", regdstE, 1);
    check("add_rd", rdE, 4);
    check("add_rs", rsE, 3);
    check("add_aluctl", alucontrolE, 3'b010);
    regwriteW = 1'b1; rdW = 5'd0; resultW = 32'd1234; instrD = 32'h0;
    tick();
    regwriteW = 1'b0; instrD = 32'h00032020;
    tick();
    check("r0_rd1", rd1E, 0);
    check("r3_rd2", rd2E, 32'hDEADBEEF);
    regwriteW = 1'b1; rdW = 5'd5; resultW = 32'd77; instrD = 32'h00A33025;
`ifdef DECODE_REGFILE_BYPASS_EN
    haz_exp = 32'd77;
`else
    haz_exp = 32'd0;
`endif
    tick();
    check("hazard_rd1", rd1E, haz_exp);
    check("or_aluctl", alucontrolE, 3'b001);
    regwriteW = 1'b0; instrD = 32'h00A03822;
    tick();
    check("r5_after_wb", rd1E, 77);
    check("sub_aluctl", alucontrolE, 3'b110);
    instrD = 32'h8C220008; isbranchtakenE = 1'b1;
    tick();
    isbranchtakenE = 1'b0;
    check("sq1_memtoreg", memtoregE, 0);
    check("sq1_regwrite", regwriteE, 0);
    check("sq1_imm", immE, 0);
    instrD = 32'hAC220004;
    tick();
    check("sq2_memwrite", memwriteE, 0);
    check("sq2_alusrc", alusrcE, 0);
    instrD = 32'h8C220008;
    tick();
    check("lw_memtoreg", memtoregE, 1);
    check("lw_regwrite", regwriteE, 1);
    check("lw_imm", immE, 8);
    check("lw_rt", rtE, 2);
    instrD = 32'hAC220004;
    tick();
    check("sw_memwrite", memwriteE, 1);
    check("sw_regwrite", regwriteE, 0);
    check("sw_imm", immE, 4);
    instrD = 32'h20010005; isbranchtakenE = 1'b1;
    tick();
    check("b2b_1", regwriteE, 0);
    tick();
    isbranchtakenE = 1'b0;
    check("b2b_2", regwriteE, 0);
    tick();
    check("b2b_3", regwriteE, 0);
    tick();
    check("b2b_resume", regwriteE, 1);
    instrD = 32'hFC000000;
    tick();
    check("illop_flag", illegalE, 1);
    check("illop_regwrite", regwriteE, 0);
    check("illop_aluctl", alucontrolE, 0);
    instrD = 32'h00000001;
    tick();
    check("illfn_flag", illegalE, 1);
    check("illfn_regwrite", regwriteE, 0);
    check("illfn_regdst", regdstE, 0);
    instrD = 32'h10220003;
    tick();
    check("beq_branch", branchE, 1);
    check("beq_aluctl", alucontrolE, 3'b110);
    check("beq_imm", immE, 3);
    check("beq_illegal", illegalE, 0);
    instrD = 32'h2001FFFF;
    tick();
    check("imm_sext", immE, 32'hFFFFFFFF);
    instrD = 32'h0022182A;
    tick();
    check("slt_aluctl", alucontrolE, 3'b111);
    instrD = 32'h20010005; isbranchtakenE = 1'b1;
    tick();
    isbranchtakenE = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_clears_squash", regwriteE, 1);
    instrD = 32'h00602020;
    tick();
    check("rst_clears_rf", rd1E, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
